// File: rtl/booth_r4_seq_multiplier_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

    // Controller states; the encoding is fixed so external probes stay meaningful.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Partial-product selection produced from one Booth window.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_sel_t;

    // One digit per bit pair of the (n+2)-bit extended multiplier.
    function automatic int unsigned iter_count(input int unsigned n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_seq_multiplier_if.sv
// Start/ready/done handshake and result bundle of the Booth multiplier.
interface booth_r4_seq_multiplier_if #(
    parameter int N = 32
);
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   operand_a;
    logic [N-1:0]   operand_b;
    logic           ready;
    logic           done;
    logic [2*N-1:0] result;
    logic           overflow;

    modport master (
        output start, signed_mode, operand_a, operand_b,
        input  ready, done, result, overflow
    );

    modport slave (
        input  start, signed_mode, operand_a, operand_b,
        output ready, done, result, overflow
    );
endinterface

// File: rtl/booth_r4_seq_multiplier_encoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a partial-product select.
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0]  window,
    output booth_sel_t  sel,
    output logic        neg
);

    // Window {b[2i+1], b[2i], b[2i-1]} -> digit in {0, +1, +2, -1, -2}.
    always_comb begin
        sel = ZERO;
        neg = 1'b0;
        case (window)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100: begin
                sel = NEG2;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                sel = NEG1;
                neg = 1'b1;
            end
            default:        sel = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, signed or unsigned at runtime.
module booth_r4_seq_multiplier
    import booth_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N / 2 + 2)
) (
    input  logic                      clk,
    input  logic                      reset,
    booth_r4_seq_multiplier_if.slave  bus
);

    localparam int unsigned ITER = iter_count(N);

    if ((N % 2) != 0 || N < 4) begin : g_bad_width
        $error("booth_r4_seq_multiplier: N must be even and >= 4");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_step;
    logic             accept;
    logic             ready_c;

    // Multiplicand and multiplier are held N+2 wide so -2A of the signed minimum fits.
    logic [N+1:0]     mcand;
    logic [N+3:0]     acc;
    logic [N+1:0]     mul;
    logic             prev;
    logic             signed_q;

    logic [2:0]       window;
    booth_sel_t       sel;
    logic             neg;
    logic [N+3:0]     mcand_ext;
    logic [N+3:0]     mag;
    logic [N+3:0]     acc_sum;
    logic [2*N+5:0]   comb_sh;
    logic [2*N-1:0]   res_fin;
    logic [N:0]       res_hi_s;
    logic             ovf_fin;

    logic [2*N-1:0]   result_q;
    logic             ovf_q;

    assign window    = {mul[1], mul[0], prev};
    assign last_step = (cnt == CNT_W'(ITER - 1));
    assign accept    = bus.start & ready_c;

    booth_r4_encoder u_encoder (
        .window (window),
        .sel    (sel),
        .neg    (neg)
    );

    // Add the selected partial product, then arithmetic-shift {acc, mul} right by two.
    always_comb begin
        mcand_ext = {{2{mcand[N+1]}}, mcand};
        mag       = '0;
        case (sel)
            POS1, NEG1: mag = mcand_ext;
            POS2, NEG2: mag = mcand_ext << 1;
            default:    mag = '0;
        endcase
        acc_sum  = acc + (neg ? -mag : mag);
        comb_sh  = {{2{acc_sum[N+3]}}, acc_sum, mul[N+1:2]};
        res_fin  = comb_sh[2*N-1:0];
        res_hi_s = res_fin[2*N-1:N-1];
        if (signed_q) begin
            ovf_fin = ~((&res_hi_s) | ~(|res_hi_s));
        end else begin
            ovf_fin = |res_fin[2*N-1:N];
        end
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) state_nxt = BUSY;
            end
            BUSY: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                ready_c  = 1'b1;
                bus.done = 1'b1;
                if (bus.start) state_nxt = BUSY;
            end
            default: state_nxt = IDLE;
        endcase
        bus.ready = ready_c;
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand    <= '0;
            acc      <= '0;
            mul      <= '0;
            prev     <= 1'b0;
            signed_q <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            mcand    <= bus.signed_mode ? {{2{bus.operand_a[N-1]}}, bus.operand_a}
                                        : {2'b00, bus.operand_a};
            mul      <= bus.signed_mode ? {{2{bus.operand_b[N-1]}}, bus.operand_b}
                                        : {2'b00, bus.operand_b};
            acc      <= '0;
            prev     <= 1'b0;
            signed_q <= bus.signed_mode;
            cnt      <= '0;
        end else if (state == BUSY) begin
            acc  <= comb_sh[2*N+5:N+2];
            mul  <= comb_sh[N+1:0];
            prev <= mul[1];
            cnt  <= cnt + CNT_W'(1);
            if (last_step) begin
                result_q <= res_fin;
                ovf_q    <= ovf_fin;
            end
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Self-checking bench for booth_r4_seq_multiplier (N=32 cycle-compared, N=8 transaction-checked).
module tb_booth_r4_seq_multiplier;

    localparam int N  = 32;
    localparam int N8 = 8;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic reset8 = 1'b0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    booth_r4_seq_multiplier_if #(.N(N))  bus ();
    booth_r4_seq_multiplier_if #(.N(N8)) bus8 ();

    booth_r4_seq_multiplier #(.N(N))  dut  (.clk(clk), .reset(reset),  .bus(bus));
    booth_r4_seq_multiplier #(.N(N8)) dut8 (.clk(clk), .reset(reset8), .bus(bus8));

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference arithmetic for N=32.
    function automatic logic [63:0] prod32(logic [31:0] a, logic [31:0] b, logic s);
        longint pa, pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            return 64'(pa * pb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic ovf32(logic [31:0] a, logic [31:0] b, logic s);
        longint p;
        longint lim;
        lim = 64'sd2147483648;
        if (s) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return (p >= lim) || (p < -lim);
        end
        return ({32'd0, a} * {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Reference arithmetic for N=8: {overflow, product}.
    function automatic logic [16:0] ref8(logic [7:0] a, logic [7:0] b, logic s);
        int p;
        logic o;
        if (s) begin
            p = int'($signed(a)) * int'($signed(b));
            o = (p > 127) || (p < -128);
        end else begin
            p = int'(a) * int'(b);
            o = p > 255;
        end
        return {o, 16'(p)};
    endfunction

    // Cycle-level behavioural model for the N=32 instance.
    logic        m_ready, m_done, m_ovf, p_ovf;
    logic [63:0] m_res, p_res;
    int          m_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ready <= 1'b1;
            m_done  <= 1'b0;
            m_res   <= '0;
            m_ovf   <= 1'b0;
            m_left  <= 0;
        end else if (m_ready && bus.start) begin
            p_res   <= prod32(bus.operand_a, bus.operand_b, bus.signed_mode);
            p_ovf   <= ovf32(bus.operand_a, bus.operand_b, bus.signed_mode);
            m_left  <= N / 2 + 1;
            m_ready <= 1'b0;
            m_done  <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_res   <= p_res;
                m_ovf   <= p_ovf;
                m_done  <= 1'b1;
                m_ready <= 1'b1;
            end
        end
    end

    // Compare all N=32 outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",    64'(bus.ready),    64'(m_ready));
            check("done",     64'(bus.done),     64'(m_done));
            check("result",   bus.result,        m_res);
            check("overflow", 64'(bus.overflow), 64'(m_ovf));
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("done_within_bound", 64'(bus.done), 64'd1);
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.operand_a   = a;
        bus.operand_b   = b;
        bus.signed_mode = s;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.operand_a   = $urandom;
        bus.operand_b   = $urandom;
        bus.signed_mode = 1'($urandom);
        wait_done(lat);
    endtask

    function automatic logic [31:0] pick32();
        logic [31:0] cv [6];
        cv = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
        if ($urandom_range(3) == 0) return cv[$urandom_range(5)];
        return $urandom;
    endfunction

    task automatic main32();
        int lat;
        op32(32'd7, 32'hFFFF_FFFD, 1'b1, lat);
        check("lat_7x-3", 64'(lat), 64'd17);
        check("res_7x-3", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
        check("ovf_7x-3", 64'(bus.overflow), 64'd0);

        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        check("res_ones_u", bus.result, 64'hFFFF_FFFE_0000_0001);
        check("ovf_ones_u", 64'(bus.overflow), 64'd1);
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
        check("res_ones_s", bus.result, 64'h1);
        check("ovf_ones_s", 64'(bus.overflow), 64'd0);

        op32(32'h8000_0000, 32'h8000_0000, 1'b1, lat);
        check("res_min_sq", bus.result, 64'h4000_0000_0000_0000);
        check("ovf_min_sq", 64'(bus.overflow), 64'd1);
        op32(32'h8000_0000, 32'h1, 1'b1, lat);
        check("res_min_x1", bus.result, 64'hFFFF_FFFF_8000_0000);
        check("ovf_min_x1", 64'(bus.overflow), 64'd0);

        // start pulses during BUSY must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.operand_a = 32'd12345; bus.operand_b = 32'hFFFF_FFB3; bus.signed_mode = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.operand_a = 32'd99; bus.operand_b = 32'd99; bus.signed_mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.operand_a = 32'd5; bus.operand_b = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check("res_ignore_start", bus.result, 64'hFFFF_FFFF_FFF1_7EDB);

        // start held in DONE: accepted on the next edge, then repeated
        bus.start = 1'b1; bus.operand_a = 32'd3; bus.operand_b = 32'd5; bus.signed_mode = 1'b0;
        @(negedge clk);
        check("b2b_done_low",  64'(bus.done),  64'd0);
        check("b2b_ready_low", 64'(bus.ready), 64'd0);
        wait_done(lat);
        check("lat_b2b", 64'(lat), 64'd17);
        check("res_b2b_1", bus.result, 64'd15);
        bus.operand_a = 32'hFFFF_FFFE; bus.operand_b = 32'd9; bus.signed_mode = 1'b1;
        @(negedge clk);
        check("b2b2_done_low", 64'(bus.done), 64'd0);
        bus.start = 1'b0;
        wait_done(lat);
        check("res_b2b_2", bus.result, 64'hFFFF_FFFF_FFFF_FFEE);
        check("ovf_b2b_2", 64'(bus.overflow), 64'd0);

        // asynchronous reset in the middle of BUSY
        @(negedge clk);
        bus.start = 1'b1; bus.operand_a = 32'd1000; bus.operand_b = 32'd1000; bus.signed_mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_ready",    64'(bus.ready),    64'd1);
        check("arst_done",     64'(bus.done),     64'd0);
        check("arst_result",   bus.result,        64'd0);
        check("arst_overflow", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        op32(32'd100000, 32'd300000, 1'b0, lat);
        check("lat_after_rst", 64'(lat), 64'd17);
        check("res_after_rst", bus.result, 64'h0000_0006_FC23_AC00);
        check("ovf_after_rst", 64'(bus.overflow), 64'd1);

        // randomized traffic, checked cycle by cycle against the model
        repeat (150) begin
            op32(pick32(), pick32(), 1'($urandom), lat);
            check("lat_rand", 64'(lat), 64'd17);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int          lat;
        logic [16:0] e;
        e = ref8(a, b, s);
        @(negedge clk);
        bus8.start = 1'b1; bus8.operand_a = a; bus8.operand_b = b; bus8.signed_mode = s;
        @(negedge clk);
        bus8.start = 1'b0; bus8.operand_a = 8'($urandom); bus8.operand_b = 8'($urandom);
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("n8_latency",  64'(lat), 64'd5);
        check("n8_result",   64'(bus8.result), 64'(e[15:0]));
        check("n8_overflow", 64'(bus8.overflow), 64'(e[16]));
    endtask

    task automatic run8();
        logic [7:0] cv [6];
        cv = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h81};
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++)
                    op8(cv[i], cv[j], 1'(s));
        repeat (1200) op8(8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;  bus.signed_mode = 1'b0;  bus.operand_a = '0;  bus.operand_b = '0;
        bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.operand_a = '0; bus8.operand_b = '0;
        #1;
        reset  = 1'b1;
        reset8 = 1'b1;
        #2;
        check("rst_ready",    64'(bus.ready),    64'd1);
        check("rst_done",     64'(bus.done),     64'd0);
        check("rst_result",   bus.result,        64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        #10;
        reset  = 1'b0;
        reset8 = 1'b0;
        chk_en = 1'b1;
        fork
            main32();
            run8();
        join
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
